// File: rtl/sdram_pattern_tester.sv
// SDRAM soak-test engine: writes a pattern over 0..addr_limit, reads it back and counts mismatches.
// One access every two cycles plus controller ack delay; request fields hold until ack.
module sdram_pattern_tester #(
    parameter int          ADDR_WIDTH    = 24,
    parameter int          DATA_WIDTH    = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          ERR_WIDTH     = 16,
    parameter int          PASS_WIDTH    = 16,
    parameter int          STOP_ON_ERROR = 0
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] addr_limit,
    output logic                  req,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ack,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic [PASS_WIDTH-1:0] pass_count,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic [DATA_WIDTH-1:0] err_got
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_VERIFY, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_mode, w_mode_nxt;
    logic [ADDR_WIDTH-1:0] r_limit, w_limit_nxt;
    logic                  r_req, w_req_nxt;
    logic                  r_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [15:0]           r_lfsr, w_lfsr_nxt;
    logic [PASS_WIDTH-1:0] r_pass, w_pass_nxt;
    logic [ERR_WIDTH-1:0]  r_err, w_err_nxt;
    logic [ADDR_WIDTH-1:0] r_err_addr, w_err_addr_nxt;
    logic [DATA_WIDTH-1:0] r_err_exp, w_err_exp_nxt;
    logic [DATA_WIDTH-1:0] r_err_got, w_err_got_nxt;
    logic [DATA_WIDTH-1:0] w_expected;
    logic [PASS_WIDTH-1:0] w_pass_inc;
    logic                  w_last;
    logic                  w_mismatch;

    function automatic logic [15:0] f_lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // A zero seed would lock the LFSR, so fall back to the base seed.
    function automatic logic [15:0] f_seed(input logic [PASS_WIDTH-1:0] p);
        logic [15:0] s;
        s = LFSR_SEED ^ 16'(p);
        return (s == 16'h0000) ? LFSR_SEED : s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [1:0] m,
                                                        input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [15:0] l);
        logic [DATA_WIDTH-1:0] d_addr;
        logic [4:0]            idx;
        d_addr = DATA_WIDTH'(a);
        idx    = 5'(a) & 5'(DATA_WIDTH - 1);
        case (m)
            2'd0:    return d_addr;
            2'd1:    return ~d_addr;
            2'd2:    return (DATA_WIDTH == 32) ? DATA_WIDTH'({l, ~l}) : DATA_WIDTH'(l);
            default: return DATA_WIDTH'(1) << idx;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_limit    <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lfsr     <= LFSR_SEED;
            r_pass     <= '0;
            r_err      <= '0;
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_limit    <= w_limit_nxt;
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_pass     <= w_pass_nxt;
            r_err      <= w_err_nxt;
            r_err_addr <= w_err_addr_nxt;
            r_err_exp  <= w_err_exp_nxt;
            r_err_got  <= w_err_got_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_limit_nxt    = r_limit;
        w_req_nxt      = r_req;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_lfsr_nxt     = r_lfsr;
        w_pass_nxt     = r_pass;
        w_err_nxt      = r_err;
        w_err_addr_nxt = r_err_addr;
        w_err_exp_nxt  = r_err_exp;
        w_err_got_nxt  = r_err_got;
        w_expected     = f_pattern(r_mode, r_addr, r_lfsr);
        w_pass_inc     = r_pass + PASS_WIDTH'(1);
        // Compare before incrementing so an all-ones limit never wraps early.
        w_last         = (r_addr == r_limit);
        w_mismatch     = (rdata != w_expected);

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt    = S_FILL;
                    w_mode_nxt     = mode;
                    w_limit_nxt    = addr_limit;
                    w_addr_nxt     = '0;
                    w_lfsr_nxt     = f_seed('0);
                    w_pass_nxt     = '0;
                    w_err_nxt      = '0;
                    w_err_addr_nxt = '0;
                    w_err_exp_nxt  = '0;
                    w_err_got_nxt  = '0;
                end
            end
            S_FILL, S_VERIFY: begin
                if (!r_req) begin
                    // Idle gap cycle after each ack: launch the next access.
                    w_req_nxt = 1'b1;
                    w_we_nxt  = (r_state == S_FILL);
                    if (r_state == S_FILL)
                        w_wdata_nxt = w_expected;
                end else if (ack) begin
                    w_req_nxt  = 1'b0;
                    w_lfsr_nxt = f_lfsr_step(r_lfsr);
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                    if (r_state == S_FILL) begin
                        if (w_last) begin
                            w_state_nxt = S_VERIFY;
                            w_addr_nxt  = '0;
                            w_lfsr_nxt  = f_seed(r_pass);
                        end
                    end else begin
                        if (w_mismatch) begin
                            if (r_err != '1)
                                w_err_nxt = r_err + ERR_WIDTH'(1);
                            if (r_err == '0) begin
                                w_err_addr_nxt = r_addr;
                                w_err_exp_nxt  = w_expected;
                                w_err_got_nxt  = rdata;
                            end
                        end
                        if (w_mismatch && (STOP_ON_ERROR != 0)) begin
                            w_state_nxt = S_DONE;
                        end else if (w_last) begin
                            w_pass_nxt = w_pass_inc;
                            w_addr_nxt = '0;
                            if (continuous) begin
                                w_state_nxt = S_FILL;
                                w_lfsr_nxt  = f_seed(w_pass_inc);
                            end else begin
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign req          = r_req;
    assign we           = r_we;
    assign addr         = r_addr;
    assign wdata        = r_wdata;
    assign busy         = (r_state == S_FILL) || (r_state == S_VERIFY);
    assign done         = (r_state == S_DONE);
    assign pass_count   = r_pass;
    assign err_count    = r_err;
    assign err_addr     = r_err_addr;
    assign err_expected = r_err_exp;
    assign err_got      = r_err_got;
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester: main instance with a delayed-ack memory model,
// plus a stop-on-error instance and a narrow instance for saturation and full address range.
module tb_sdram_pattern_tester;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    typedef struct packed {
        logic        we;
        logic [23:0] a;
        logic [15:0] d;
    } acc_t;

    // Main instance
    logic        m_start, m_cont, m_req, m_we, m_ack, m_busy, m_done;
    logic [1:0]  m_mode;
    logic [23:0] m_limit, m_addr, m_err_addr;
    logic [15:0] m_wdata, m_rdata, m_pass, m_err, m_err_exp, m_err_got;

    // Stop-on-error instance
    logic        s_start, s_cont, s_req, s_we, s_ack, s_busy, s_done;
    logic [1:0]  s_mode;
    logic [23:0] s_limit, s_addr, s_err_addr;
    logic [15:0] s_wdata, s_rdata, s_pass, s_err_exp, s_err_got, s_err;

    // Narrow instance: 5-bit addresses, 4-bit error counter
    logic        t_start, t_cont, t_req, t_we, t_ack, t_busy, t_done;
    logic [1:0]  t_mode;
    logic [4:0]  t_limit, t_addr, t_err_addr;
    logic [15:0] t_wdata, t_rdata, t_pass, t_err_exp, t_err_got;
    logic [3:0]  t_err;

    logic [15:0]  mem     [0:255];
    logic [15:0]  corrupt [0:255];
    acc_t         log_q[$];
    int unsigned  ack_max;
    int unsigned  wait_cnt;
    int unsigned  cur_delay;

    sdram_pattern_tester u_main (
        .clk(clk), .reset_in(rst_n), .start(m_start), .continuous(m_cont), .mode(m_mode),
        .addr_limit(m_limit), .req(m_req), .we(m_we), .addr(m_addr), .wdata(m_wdata),
        .ack(m_ack), .rdata(m_rdata), .busy(m_busy), .done(m_done), .pass_count(m_pass),
        .err_count(m_err), .err_addr(m_err_addr), .err_expected(m_err_exp), .err_got(m_err_got)
    );

    sdram_pattern_tester #(.STOP_ON_ERROR(1)) u_stop (
        .clk(clk), .reset_in(rst_n), .start(s_start), .continuous(s_cont), .mode(s_mode),
        .addr_limit(s_limit), .req(s_req), .we(s_we), .addr(s_addr), .wdata(s_wdata),
        .ack(s_ack), .rdata(s_rdata), .busy(s_busy), .done(s_done), .pass_count(s_pass),
        .err_count(s_err), .err_addr(s_err_addr), .err_expected(s_err_exp), .err_got(s_err_got)
    );

    sdram_pattern_tester #(.ADDR_WIDTH(5), .ERR_WIDTH(4)) u_sat (
        .clk(clk), .reset_in(rst_n), .start(t_start), .continuous(t_cont), .mode(t_mode),
        .addr_limit(t_limit), .req(t_req), .we(t_we), .addr(t_addr), .wdata(t_wdata),
        .ack(t_ack), .rdata(t_rdata), .busy(t_busy), .done(t_done), .pass_count(t_pass),
        .err_count(t_err), .err_addr(t_err_addr), .err_expected(t_err_exp), .err_got(t_err_got)
    );

    // Zero-delay controllers: stop instance flips bit 0 at addresses 3 and 7, narrow one always returns DEAD.
    assign s_ack   = s_req;
    assign s_rdata = s_addr[15:0] ^ {15'd0, (s_addr == 24'd3) || (s_addr == 24'd7)};
    assign t_ack   = t_req;
    assign t_rdata = 16'hDEAD;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    // Memory model for the main instance: ack after a random 0..ack_max cycle wait.
    initial begin
        m_ack = 1'b0; m_rdata = '0; wait_cnt = 0; cur_delay = 0;
        forever begin
            @(posedge clk); #1;
            if (m_ack) begin
                m_ack     = 1'b0;
                wait_cnt  = 0;
                cur_delay = $urandom_range(0, ack_max);
            end else if (m_req && rst_n) begin
                if (wait_cnt >= cur_delay) begin
                    m_ack = 1'b1;
                    if (m_we) begin
                        mem[m_addr[7:0]] = m_wdata;
                        log_q.push_back({1'b1, m_addr, m_wdata});
                    end else begin
                        m_rdata = mem[m_addr[7:0]] ^ corrupt[m_addr[7:0]];
                        log_q.push_back({1'b0, m_addr, m_rdata});
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'h5555;
            corrupt[i] = 16'h0000;
        end
        log_q.delete();
    endtask

    task automatic pulse_main_start();
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
    endtask

    task automatic wait_main_done(input int max_cycles);
        for (int i = 0; i < max_cycles && m_done !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_req, m_we, m_busy, m_done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {m_req, m_we, m_busy, m_done});
        end
        n_checks++;
        if ({m_addr, m_wdata} !== 40'd0) begin
            n_fail++; $display("FAIL reset_bus: got %h expected 0", {m_addr, m_wdata});
        end
        n_checks++;
        if ({m_pass, m_err} !== 32'd0) begin
            n_fail++; $display("FAIL reset_counts: got %h expected 0", {m_pass, m_err});
        end
        n_checks++;
        if ({m_err_addr, m_err_exp, m_err_got} !== 56'd0) begin
            n_fail++; $display("FAIL reset_capture: got %h expected 0", {m_err_addr, m_err_exp, m_err_got});
        end
        n_checks++;
        if ({s_busy, s_done, s_req, t_busy, t_done, t_req} !== 6'd0) begin
            n_fail++; $display("FAIL reset_other: got %b expected 000000", {s_busy, s_done, s_req, t_busy, t_done, t_req});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_busy, m_done, m_req} !== 3'b000) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {m_busy, m_done, m_req});
        end
    endtask

    task automatic test_mode0_fill_verify();
        clear_model();
        ack_max = 0; m_cont = 1'b0; m_mode = 2'd0; m_limit = 24'd15;
        pulse_main_start();
        n_checks++;
        if ({m_busy, m_req} !== 2'b10) begin
            n_fail++; $display("FAIL m0_first_gap: busy,req got %b expected 10", {m_busy, m_req});
        end
        @(negedge clk);
        n_checks++;
        if ({m_req, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 24'd0, 16'd0}) begin
            n_fail++; $display("FAIL m0_first_req: got %h expected %h", {m_req, m_we, m_addr, m_wdata}, {1'b1, 1'b1, 24'd0, 16'd0});
        end
        wait_main_done(300);
        n_checks++;
        if ({m_done, m_busy, m_pass, m_err} !== {1'b1, 1'b0, 16'd1, 16'd0}) begin
            n_fail++; $display("FAIL m0_result: done,busy,pass,err got %h expected %h", {m_done, m_busy, m_pass, m_err}, {1'b1, 1'b0, 16'd1, 16'd0});
        end
        n_checks++;
        if (log_q.size() != 32) begin
            n_fail++; $display("FAIL m0_access_count: got %0d expected 32", log_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks += 2;
                if (log_q[i] !== {1'b1, 24'(i), 16'(i)}) begin
                    n_fail++; $display("FAIL m0_write[%0d]: got %h expected %h", i, log_q[i], {1'b1, 24'(i), 16'(i)});
                end
                if (log_q[16+i] !== {1'b0, 24'(i), 16'(i)}) begin
                    n_fail++; $display("FAIL m0_read[%0d]: got %h expected %h", i, log_q[16+i], {1'b0, 24'(i), 16'(i)});
                end
            end
        end
    endtask

    task automatic test_mode1_error();
        clear_model();
        corrupt[5] = 16'h0001;
        m_mode = 2'd1; m_limit = 24'd15;
        pulse_main_start();
        n_checks++;
        if ({m_pass, m_err} !== 32'd0) begin
            n_fail++; $display("FAIL m1_restart_clear: pass,err got %h expected 0", {m_pass, m_err});
        end
        wait_main_done(300);
        n_checks++;
        if ({m_done, m_pass, m_err} !== {1'b1, 16'd1, 16'd1}) begin
            n_fail++; $display("FAIL m1_counts: done,pass,err got %h expected %h", {m_done, m_pass, m_err}, {1'b1, 16'd1, 16'd1});
        end
        n_checks++;
        if ({m_err_addr, m_err_exp, m_err_got} !== {24'd5, 16'hFFFA, 16'hFFFB}) begin
            n_fail++; $display("FAIL m1_capture: got %h expected %h", {m_err_addr, m_err_exp, m_err_got}, {24'd5, 16'hFFFA, 16'hFFFB});
        end
        corrupt[5] = 16'h0000;
    endtask

    task automatic test_limit_zero();
        clear_model();
        m_mode = 2'd0; m_limit = 24'd0;
        pulse_main_start();
        wait_main_done(100);
        n_checks++;
        if ({m_done, m_pass, m_err} !== {1'b1, 16'd1, 16'd0}) begin
            n_fail++; $display("FAIL lim0_result: got %h expected %h", {m_done, m_pass, m_err}, {1'b1, 16'd1, 16'd0});
        end
        n_checks++;
        if (log_q.size() != 2) begin
            n_fail++; $display("FAIL lim0_access_count: got %0d expected 2", log_q.size());
        end else if ({log_q[0], log_q[1]} !== {1'b1, 24'd0, 16'd0, 1'b0, 24'd0, 16'd0}) begin
            n_fail++; $display("FAIL lim0_accesses: got %h %h expected write then read of addr 0", log_q[0], log_q[1]);
        end
    endtask

    task automatic test_mode2_continuous();
        logic [15:0] l;
        clear_model();
        m_mode = 2'd2; m_limit = 24'd3; m_cont = 1'b1;
        pulse_main_start();
        for (int i = 0; i < 500 && m_pass !== 16'd2; i++) @(negedge clk);
        m_cont = 1'b0;
        wait_main_done(500);
        n_checks++;
        if ({m_done, m_pass, m_err} !== {1'b1, 16'd3, 16'd0}) begin
            n_fail++; $display("FAIL m2_result: done,pass,err got %h expected %h", {m_done, m_pass, m_err}, {1'b1, 16'd3, 16'd0});
        end
        n_checks++;
        if (log_q.size() != 24) begin
            n_fail++; $display("FAIL m2_access_count: got %0d expected 24", log_q.size());
        end else begin
            n_checks++;
            if ({log_q[0].d, log_q[1].d, log_q[8].d, log_q[9].d} !== {16'hACE1, 16'hE270, 16'hACE0, 16'h5670}) begin
                n_fail++; $display("FAIL m2_seed_words: got %h %h %h %h expected ace1 e270 ace0 5670",
                                   log_q[0].d, log_q[1].d, log_q[8].d, log_q[9].d);
            end
            for (int p = 0; p < 3; p++) begin
                l = 16'hACE1 ^ 16'(p);
                for (int i = 0; i < 4; i++) begin
                    n_checks += 2;
                    if (log_q[p*8+i] !== {1'b1, 24'(i), l}) begin
                        n_fail++; $display("FAIL m2_fill p%0d[%0d]: got %h expected %h", p, i, log_q[p*8+i], {1'b1, 24'(i), l});
                    end
                    if (log_q[p*8+4+i] !== {1'b0, 24'(i), l}) begin
                        n_fail++; $display("FAIL m2_verify p%0d[%0d]: got %h expected %h", p, i, log_q[p*8+4+i], {1'b0, 24'(i), l});
                    end
                    l = lfsr_step(l);
                end
            end
        end
    endtask

    task automatic test_random_ack();
        logic        p_req, p_ack, p_gap;
        logic [41:0] p_fields;
        logic [15:0] exp_d;
        clear_model();
        ack_max = 7; m_mode = 2'd3; m_limit = 24'd20;
        pulse_main_start();
        p_req = 1'b0; p_ack = 1'b0; p_gap = 1'b0; p_fields = '0;
        for (int i = 0; i < 2000 && m_done !== 1'b1; i++) begin
            if (p_req && !p_ack) begin
                n_checks++;
                if ({m_req, m_we, m_addr, m_wdata} !== p_fields) begin
                    n_fail++; $display("FAIL hold_while_waiting: got %h expected %h", {m_req, m_we, m_addr, m_wdata}, p_fields);
                end
            end
            if (p_req && p_ack) begin
                n_checks++;
                if (m_req !== 1'b0) begin
                    n_fail++; $display("FAIL gap_after_ack: req got %b expected 0", m_req);
                end
            end
            if (p_gap && m_busy) begin
                n_checks++;
                if (m_req !== 1'b1) begin
                    n_fail++; $display("FAIL req_after_gap: req got %b expected 1", m_req);
                end
            end
            p_gap    = p_req && p_ack;
            p_req    = m_req;
            p_ack    = m_ack;
            p_fields = {m_req, m_we, m_addr, m_wdata};
            // Start while busy must be ignored.
            if (i == 10) begin m_start = 1'b1; m_mode = 2'd0; m_limit = 24'd2; end
            if (i == 11) m_start = 1'b0;
            @(negedge clk);
        end
        ack_max = 0;
        n_checks++;
        if ({m_done, m_pass, m_err} !== {1'b1, 16'd1, 16'd0}) begin
            n_fail++; $display("FAIL rnd_result: done,pass,err got %h expected %h", {m_done, m_pass, m_err}, {1'b1, 16'd1, 16'd0});
        end
        n_checks++;
        if (log_q.size() != 42) begin
            n_fail++; $display("FAIL rnd_access_count: got %0d expected 42", log_q.size());
        end else begin
            n_checks++;
            if (log_q[17].d !== 16'h0002) begin
                n_fail++; $display("FAIL rnd_walk_wrap: got %h expected 0002", log_q[17].d);
            end
            for (int a = 0; a < 21; a++) begin
                exp_d = 16'h0001 << (a % 16);
                n_checks++;
                if ({log_q[a], log_q[21+a]} !== {1'b1, 24'(a), exp_d, 1'b0, 24'(a), exp_d}) begin
                    n_fail++; $display("FAIL rnd_walk[%0d]: got %h %h expected data %h", a, log_q[a], log_q[21+a], exp_d);
                end
            end
        end
    endtask

    task automatic test_stop_on_error();
        logic saw4, chk_next, checked;
        saw4 = 1'b0; chk_next = 1'b0; checked = 1'b0;
        s_mode = 2'd0; s_limit = 24'd15;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (chk_next) begin
                n_checks++;
                checked  = 1'b1;
                chk_next = 1'b0;
                if (s_done !== 1'b1) begin
                    n_fail++; $display("FAIL stop_done_next_cycle: done got %b expected 1", s_done);
                end
            end
            if (s_req && s_ack && !s_we && s_addr == 24'd3) chk_next = 1'b1;
            if (s_req && s_ack && !s_we && s_addr == 24'd4) saw4 = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if ({checked, saw4} !== 2'b10) begin
            n_fail++; $display("FAIL stop_reads: saw addr3,addr4 got %b expected 10", {checked, saw4});
        end
        n_checks++;
        if ({s_done, s_pass, s_err} !== {1'b1, 16'd0, 16'd1}) begin
            n_fail++; $display("FAIL stop_counts: done,pass,err got %h expected %h", {s_done, s_pass, s_err}, {1'b1, 16'd0, 16'd1});
        end
        n_checks++;
        if ({s_err_addr, s_err_exp, s_err_got} !== {24'd3, 16'd3, 16'd2}) begin
            n_fail++; $display("FAIL stop_capture: got %h expected %h", {s_err_addr, s_err_exp, s_err_got}, {24'd3, 16'd3, 16'd2});
        end
    endtask

    task automatic test_saturation_full_range();
        int reads;
        reads = 0;
        t_mode = 2'd0; t_limit = 5'h1F;
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        for (int i = 0; i < 400 && t_done !== 1'b1; i++) begin
            if (t_req && t_ack && !t_we) reads++;
            @(negedge clk);
        end
        n_checks++;
        if ({t_done, t_pass} !== {1'b1, 16'd1} || reads != 32) begin
            n_fail++; $display("FAIL sat_full_range: done,pass got %h reads %0d expected 10001 reads 32", {t_done, t_pass}, reads);
        end
        n_checks++;
        if (t_err !== 4'hF) begin
            n_fail++; $display("FAIL sat_err_count: got %h expected f", t_err);
        end
        n_checks++;
        if ({t_err_addr, t_err_exp, t_err_got} !== {5'd0, 16'h0000, 16'hDEAD}) begin
            n_fail++; $display("FAIL sat_capture: got %h expected %h", {t_err_addr, t_err_exp, t_err_got}, {5'd0, 16'h0000, 16'hDEAD});
        end
    endtask

    task automatic test_reset_midrun();
        clear_model();
        ack_max = 3; m_mode = 2'd0; m_limit = 24'd15;
        pulse_main_start();
        for (int i = 0; i < 500 && !(m_busy && m_req && !m_we && m_addr == 24'd4); i++) @(negedge clk);
        n_checks++;
        if ({m_busy, m_req, m_we} !== 3'b110) begin
            n_fail++; $display("FAIL rst_mid_reached: busy,req,we got %b expected 110", {m_busy, m_req, m_we});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_req, m_we, m_busy, m_done, m_addr, m_wdata} !== 44'd0) begin
            n_fail++; $display("FAIL rst_async_outputs: got %h expected 0", {m_req, m_we, m_busy, m_done, m_addr, m_wdata});
        end
        n_checks++;
        if ({m_pass, m_err, m_err_addr, m_err_exp, m_err_got} !== 88'd0) begin
            n_fail++; $display("FAIL rst_async_counts: got %h expected 0", {m_pass, m_err, m_err_addr, m_err_exp, m_err_got});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_max = 0;
        @(negedge clk);
        clear_model();
        m_limit = 24'd7;
        pulse_main_start();
        wait_main_done(200);
        n_checks++;
        if ({m_done, m_pass, m_err} !== {1'b1, 16'd1, 16'd0} || log_q.size() != 16) begin
            n_fail++; $display("FAIL rst_rerun: done,pass,err got %h accesses %0d expected %h accesses 16",
                               {m_done, m_pass, m_err}, log_q.size(), {1'b1, 16'd1, 16'd0});
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; ack_max = 0;
        rst_n = 1'b0;
        m_start = 1'b0; m_cont = 1'b0; m_mode = 2'd0; m_limit = '0;
        s_start = 1'b0; s_cont = 1'b0; s_mode = 2'd0; s_limit = '0;
        t_start = 1'b0; t_cont = 1'b0; t_mode = 2'd0; t_limit = '0;
        clear_model();
        @(negedge clk);
        test_reset();
        test_mode0_fill_verify();
        test_mode1_error();
        test_limit_zero();
        test_mode2_continuous();
        test_random_ack();
        test_stop_on_error();
        test_saturation_full_range();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
